// File: rtl/alu_flags_pkg.sv
// Shared constants and the stack-op decode for the ALU flag register and its save stack.
package alu_flags_pkg;

   localparam int FLAG_ZERO     = 0;
   localparam int FLAG_CARRY    = 1;
   localparam int FLAG_SIGN     = 2;
   localparam int NUM_FLAGS_DEF = 3;

   typedef enum logic [1:0] {
      OP_NONE     = 2'd0,
      OP_PUSH     = 2'd1,
      OP_POP      = 2'd2,
      OP_CONFLICT = 2'd3
   } stack_op_e;

   function automatic stack_op_e decode_op(input logic push, input logic pop);
      stack_op_e op;
      case ({push, pop})
         2'b10:   op = OP_PUSH;
         2'b01:   op = OP_POP;
         2'b11:   op = OP_CONFLICT;
         default: op = OP_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/flag_lifo.sv
// Flag save stack: storage, occupancy count and full/empty decode.
// Reports overflow/underflow attempts; push and pop are expected mutually exclusive.
module flag_lifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             top,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full      = (depth == CW'(DEPTH));
   assign empty     = (depth == '0);
   assign push_ok   = push & ~full & ~clr;
   assign pop_ok    = pop & ~empty & ~clr;
   assign overflow  = push & full;
   assign underflow = pop & empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       depth <= '0;
      else if (clr)     depth <= '0;
      else if (push_ok) depth <= depth + CW'(1);
      else if (pop_ok)  depth <= depth - CW'(1);
   end

   // Storage carries no reset; entries above depth are never read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push_ok && depth == CW'(i)) mem[i] <= din;
      end
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (depth == CW'(i + 1)) top = mem[i];
      end
   end

endmodule

// File: rtl/alu_flags_stack.sv
// ALU status-flag register with masked per-flag writes, a save/restore stack and a sticky error.
// Priority each cycle: CLR, then stack operation, then flag write.
module alu_flags_stack
   import alu_flags_pkg::*;
#(
   parameter int NUM_FLAGS = NUM_FLAGS_DEF,
   parameter int DEPTH     = 4
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic [NUM_FLAGS-1:0]         IN_FLAGS,
   input  logic [NUM_FLAGS-1:0]         IN_WE,
   input  logic                         PUSH,
   input  logic                         POP,
   input  logic                         CLR,
   input  logic                         ERR_CLR,
   output logic [NUM_FLAGS-1:0]         OUT_FLAGS,
   output logic [$clog2(DEPTH+1)-1:0]   OUT_DEPTH,
   output logic                         OUT_FULL,
   output logic                         OUT_EMPTY,
   output logic                         OUT_ERR
);

   stack_op_e            op;
   logic                 push_go;
   logic                 pop_go;
   logic                 overflow;
   logic                 underflow;
   logic                 err_event;
   logic [NUM_FLAGS-1:0] stack_top;
   logic [NUM_FLAGS-1:0] flags_next;

   assign op        = decode_op(PUSH, POP);
   assign push_go   = (op == OP_PUSH);
   assign pop_go    = (op == OP_POP);
   assign err_event = overflow | underflow | (op == OP_CONFLICT);

   flag_lifo #(
      .WIDTH (NUM_FLAGS),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk       (CLK),
      .rst_n     (reset),
      .clr       (CLR),
      .push      (push_go),
      .pop       (pop_go),
      .din       (OUT_FLAGS),
      .top       (stack_top),
      .depth     (OUT_DEPTH),
      .full      (OUT_FULL),
      .empty     (OUT_EMPTY),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // A successful pop restores the whole vector; anything else falls through to the masked write.
   always_comb begin
      flags_next = (OUT_FLAGS & ~IN_WE) | (IN_FLAGS & IN_WE);
      if (pop_go && !OUT_EMPTY) flags_next = stack_top;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)   OUT_FLAGS <= '0;
      else if (CLR) OUT_FLAGS <= '0;
      else          OUT_FLAGS <= flags_next;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)         OUT_ERR <= 1'b0;
      else if (CLR)       OUT_ERR <= 1'b0;
      else if (err_event) OUT_ERR <= 1'b1;
      else if (ERR_CLR)   OUT_ERR <= 1'b0;
   end

endmodule

// File: tb/tb_alu_flags_stack.sv
// Directed bench for alu_flags_stack with NUM_FLAGS=3, DEPTH=4.
module tb_alu_flags_stack;

   logic       CLK = 1'b0;
   logic       reset;
   logic [2:0] IN_FLAGS;
   logic [2:0] IN_WE;
   logic       PUSH;
   logic       POP;
   logic       CLR;
   logic       ERR_CLR;
   logic [2:0] OUT_FLAGS;
   logic [2:0] OUT_DEPTH;
   logic       OUT_FULL;
   logic       OUT_EMPTY;
   logic       OUT_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   alu_flags_stack #(.NUM_FLAGS(3), .DEPTH(4)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .IN_FLAGS  (IN_FLAGS),
      .IN_WE     (IN_WE),
      .PUSH      (PUSH),
      .POP       (POP),
      .CLR       (CLR),
      .ERR_CLR   (ERR_CLR),
      .OUT_FLAGS (OUT_FLAGS),
      .OUT_DEPTH (OUT_DEPTH),
      .OUT_FULL  (OUT_FULL),
      .OUT_EMPTY (OUT_EMPTY),
      .OUT_ERR   (OUT_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic idle();
      IN_FLAGS = 3'b000; IN_WE = 3'b000;
      PUSH = 0; POP = 0; CLR = 0; ERR_CLR = 0;
   endtask

   // Applies the currently driven inputs for one edge, then returns them to idle.
   task automatic cyc();
      @(posedge CLK); #1;
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      #3;
      n_checks++; if (OUT_FLAGS !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", OUT_FLAGS); end
      n_checks++; if (OUT_DEPTH !== 3'd0)   begin n_fail++; $display("FAIL reset_depth got %0d exp 0", OUT_DEPTH); end
      n_checks++; if (OUT_EMPTY !== 1'b1)   begin n_fail++; $display("FAIL reset_empty got %b exp 1", OUT_EMPTY); end
      n_checks++; if (OUT_FULL !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %b exp 0", OUT_FULL); end
      n_checks++; if (OUT_ERR !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %b exp 0", OUT_ERR); end
      #10 reset = 1'b1;
   endtask

   task automatic test_masked_write();
      IN_FLAGS = 3'b111; IN_WE = 3'b010; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b010) begin n_fail++; $display("FAIL masked_write got %b exp 010", OUT_FLAGS); end
      IN_FLAGS = 3'b001; IN_WE = 3'b011; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b001) begin n_fail++; $display("FAIL masked_write2 got %b exp 001", OUT_FLAGS); end
   endtask

   task automatic test_push_restore();
      IN_FLAGS = 3'b101; IN_WE = 3'b111; cyc();
      IN_FLAGS = 3'b010; IN_WE = 3'b111; PUSH = 1; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b010) begin n_fail++; $display("FAIL push_flags got %b exp 010", OUT_FLAGS); end
      n_checks++; if (OUT_DEPTH !== 3'd1)   begin n_fail++; $display("FAIL push_depth got %0d exp 1", OUT_DEPTH); end
      IN_FLAGS = 3'b111; IN_WE = 3'b111; POP = 1; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b101) begin n_fail++; $display("FAIL pop_flags got %b exp 101", OUT_FLAGS); end
      n_checks++; if (OUT_DEPTH !== 3'd0)   begin n_fail++; $display("FAIL pop_depth got %0d exp 0", OUT_DEPTH); end
      n_checks++; if (OUT_EMPTY !== 1'b1)   begin n_fail++; $display("FAIL pop_empty got %b exp 1", OUT_EMPTY); end
      n_checks++; if (OUT_ERR !== 1'b0)     begin n_fail++; $display("FAIL push_restore_err got %b exp 0", OUT_ERR); end
   endtask

   task automatic test_overflow();
      logic [2:0] exp_pop [4];
      exp_pop[0] = 3'd3; exp_pop[1] = 3'd2; exp_pop[2] = 3'd1; exp_pop[3] = 3'd0;
      IN_FLAGS = 3'd0; IN_WE = 3'b111; cyc();
      // Each push saves the pre-write value while loading the next one.
      for (int i = 0; i < 4; i++) begin
         IN_FLAGS = 3'((i + 1) % 4); IN_WE = 3'b111; PUSH = 1; cyc();
      end
      n_checks++; if (OUT_FULL !== 1'b1)  begin n_fail++; $display("FAIL ovf_full got %b exp 1", OUT_FULL); end
      n_checks++; if (OUT_DEPTH !== 3'd4) begin n_fail++; $display("FAIL ovf_depth4 got %0d exp 4", OUT_DEPTH); end
      n_checks++; if (OUT_ERR !== 1'b0)   begin n_fail++; $display("FAIL ovf_err_pre got %b exp 0", OUT_ERR); end
      IN_FLAGS = 3'b110; IN_WE = 3'b100; PUSH = 1; cyc();
      n_checks++; if (OUT_ERR !== 1'b1)     begin n_fail++; $display("FAIL ovf_err got %b exp 1", OUT_ERR); end
      n_checks++; if (OUT_DEPTH !== 3'd4)   begin n_fail++; $display("FAIL ovf_depth_hold got %0d exp 4", OUT_DEPTH); end
      n_checks++; if (OUT_FLAGS !== 3'b100) begin n_fail++; $display("FAIL ovf_write got %b exp 100", OUT_FLAGS); end
      ERR_CLR = 1; cyc();
      n_checks++; if (OUT_ERR !== 1'b0) begin n_fail++; $display("FAIL ovf_errclr got %b exp 0", OUT_ERR); end
      for (int i = 0; i < 4; i++) begin
         POP = 1; cyc();
         n_checks++;
         if (OUT_FLAGS !== exp_pop[i]) begin
            n_fail++; $display("FAIL ovf_pop%0d got %0d exp %0d", i, OUT_FLAGS, exp_pop[i]);
         end
      end
      n_checks++; if (OUT_EMPTY !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got %b exp 1", OUT_EMPTY); end
      n_checks++; if (OUT_ERR !== 1'b0)   begin n_fail++; $display("FAIL ovf_pop_err got %b exp 0", OUT_ERR); end
   endtask

   task automatic test_conflict();
      IN_FLAGS = 3'b110; IN_WE = 3'b111; cyc();
      PUSH = 1; cyc();
      IN_FLAGS = 3'b001; IN_WE = 3'b111; PUSH = 1; POP = 1; cyc();
      n_checks++; if (OUT_DEPTH !== 3'd1)   begin n_fail++; $display("FAIL conf_depth got %0d exp 1", OUT_DEPTH); end
      n_checks++; if (OUT_ERR !== 1'b1)     begin n_fail++; $display("FAIL conf_err got %b exp 1", OUT_ERR); end
      n_checks++; if (OUT_FLAGS !== 3'b001) begin n_fail++; $display("FAIL conf_write got %b exp 001", OUT_FLAGS); end
      POP = 1; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b110) begin n_fail++; $display("FAIL conf_pop got %b exp 110", OUT_FLAGS); end
      ERR_CLR = 1; POP = 1; cyc();
      n_checks++; if (OUT_ERR !== 1'b1) begin n_fail++; $display("FAIL errclr_vs_underflow got %b exp 1", OUT_ERR); end
      ERR_CLR = 1; cyc();
      n_checks++; if (OUT_ERR !== 1'b0) begin n_fail++; $display("FAIL errclr_alone got %b exp 0", OUT_ERR); end
   endtask

   task automatic test_clr();
      IN_FLAGS = 3'b011; IN_WE = 3'b111; cyc();
      for (int i = 0; i < 3; i++) begin PUSH = 1; cyc(); end
      POP = 1; PUSH = 1; cyc();
      n_checks++; if (OUT_DEPTH !== 3'd3) begin n_fail++; $display("FAIL clr_pre_depth got %0d exp 3", OUT_DEPTH); end
      n_checks++; if (OUT_ERR !== 1'b1)   begin n_fail++; $display("FAIL clr_pre_err got %b exp 1", OUT_ERR); end
      CLR = 1; PUSH = 1; IN_FLAGS = 3'b111; IN_WE = 3'b111; cyc();
      n_checks++; if (OUT_DEPTH !== 3'd0)   begin n_fail++; $display("FAIL clr_depth got %0d exp 0", OUT_DEPTH); end
      n_checks++; if (OUT_FLAGS !== 3'b000) begin n_fail++; $display("FAIL clr_flags got %b exp 000", OUT_FLAGS); end
      n_checks++; if (OUT_ERR !== 1'b0)     begin n_fail++; $display("FAIL clr_err got %b exp 0", OUT_ERR); end
      n_checks++; if (OUT_EMPTY !== 1'b1)   begin n_fail++; $display("FAIL clr_empty got %b exp 1", OUT_EMPTY); end
      POP = 1; cyc();
      n_checks++; if (OUT_ERR !== 1'b1) begin n_fail++; $display("FAIL clr_discard got %b exp 1", OUT_ERR); end
      CLR = 1; cyc();
   endtask

   task automatic test_reset_mid();
      IN_FLAGS = 3'b111; IN_WE = 3'b111; cyc();
      PUSH = 1; cyc();
      PUSH = 1; cyc();
      n_checks++; if (OUT_DEPTH !== 3'd2)   begin n_fail++; $display("FAIL rmid_pre_depth got %0d exp 2", OUT_DEPTH); end
      n_checks++; if (OUT_FLAGS !== 3'b111) begin n_fail++; $display("FAIL rmid_pre_flags got %b exp 111", OUT_FLAGS); end
      #1 reset = 1'b0;
      #1;
      n_checks++; if (OUT_FLAGS !== 3'b000) begin n_fail++; $display("FAIL rmid_flags got %b exp 000", OUT_FLAGS); end
      n_checks++; if (OUT_DEPTH !== 3'd0)   begin n_fail++; $display("FAIL rmid_depth got %0d exp 0", OUT_DEPTH); end
      n_checks++; if (OUT_EMPTY !== 1'b1)   begin n_fail++; $display("FAIL rmid_empty got %b exp 1", OUT_EMPTY); end
      @(negedge CLK) reset = 1'b1;
      POP = 1; cyc();
      n_checks++; if (OUT_ERR !== 1'b1)   begin n_fail++; $display("FAIL rmid_pop_err got %b exp 1", OUT_ERR); end
      n_checks++; if (OUT_DEPTH !== 3'd0) begin n_fail++; $display("FAIL rmid_pop_depth got %0d exp 0", OUT_DEPTH); end
      CLR = 1; cyc();
   endtask

   task automatic test_back_to_back();
      IN_FLAGS = 3'b100; IN_WE = 3'b111; cyc();
      IN_FLAGS = 3'b011; IN_WE = 3'b111; PUSH = 1; cyc();
      POP = 1; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b100) begin n_fail++; $display("FAIL b2b_pop1 got %b exp 100", OUT_FLAGS); end
      IN_FLAGS = 3'b010; IN_WE = 3'b010; PUSH = 1; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b110) begin n_fail++; $display("FAIL b2b_write got %b exp 110", OUT_FLAGS); end
      POP = 1; cyc();
      n_checks++; if (OUT_FLAGS !== 3'b100) begin n_fail++; $display("FAIL b2b_pop2 got %b exp 100", OUT_FLAGS); end
      n_checks++; if (OUT_ERR !== 1'b0)     begin n_fail++; $display("FAIL b2b_err got %b exp 0", OUT_ERR); end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      @(posedge CLK); #1;
      test_masked_write();
      test_push_restore();
      test_overflow();
      test_conflict();
      test_clr();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
